// File: rtl/eprom_fetch_ctrl.sv
// Read sequencer for a 2732-style 4Kx8 EPROM: address setup, E/G strobe, timed sample, valid/ready response.
// Define EPROM_FETCH_CACHE_EN to add a one-entry last-byte cache that answers repeat reads without a bus cycle.
module eprom_fetch_ctrl #(
  parameter int ADDR_W          = 12,
  parameter int DATA_W          = 8,
  parameter int ACCESS_CYCLES   = 4,
  parameter int RECOVERY_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_e_n,
  output logic              rom_g_n,
  input  logic [DATA_W-1:0] rom_q,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, RESP, RECOVER} state_t;

  localparam logic [7:0] ACC_INIT = 8'(ACCESS_CYCLES - 1);
  localparam logic [7:0] REC_INIT = 8'(RECOVERY_CYCLES - 1);

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   romAddr_q, romAddr_d;
  logic                romOff_q, romOff_d;
  logic                rspValid_q, rspValid_d;
  logic [DATA_W-1:0]   rspData_q, rspData_d;
  logic                skipRecover;

`ifdef EPROM_FETCH_CACHE_EN
  logic [ADDR_W-1:0]   cacheAddr_q, cacheAddr_d;
  logic [DATA_W-1:0]   cacheData_q, cacheData_d;
  logic                cacheValid_q, cacheValid_d;
  logic                hitResp_q, hitResp_d;
  logic                cacheHit;

  assign cacheHit    = cacheValid_q && (req_addr == cacheAddr_q);
  assign skipRecover = hitResp_q;
`else
  assign skipRecover = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    romAddr_d  = romAddr_q;
    romOff_d   = romOff_q;
    rspValid_d = rspValid_q;
    rspData_d  = rspData_q;
`ifdef EPROM_FETCH_CACHE_EN
    cacheAddr_d  = cacheAddr_q;
    cacheData_d  = cacheData_q;
    cacheValid_d = cacheValid_q;
    hitResp_d    = hitResp_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
`ifdef EPROM_FETCH_CACHE_EN
          if (cacheHit) begin
            rspData_d  = cacheData_q;
            rspValid_d = 1'b1;
            hitResp_d  = 1'b1;
            state_d    = RESP;
          end else begin
            romAddr_d = req_addr;
            hitResp_d = 1'b0;
            state_d   = SETUP;
          end
`else
          romAddr_d = req_addr;
          state_d   = SETUP;
`endif
        end
      end
      SETUP: begin
        romOff_d = 1'b0;
        cnt_d    = ACC_INIT;
        state_d  = ACCESS;
      end
      ACCESS: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          rspData_d  = rom_q;
          rspValid_d = 1'b1;
          romOff_d   = 1'b1;
          state_d    = RESP;
`ifdef EPROM_FETCH_CACHE_EN
          cacheAddr_d  = romAddr_q;
          cacheData_d  = rom_q;
          cacheValid_d = 1'b1;
`endif
        end
      end
      RESP: begin
        // A cache-hit response never touched the bus, so it needs no recovery gap.
        if (rsp_ready) begin
          rspValid_d = 1'b0;
          if (RECOVERY_CYCLES == 0 || skipRecover) begin
            state_d = IDLE;
          end else begin
            cnt_d   = REC_INIT;
            state_d = RECOVER;
          end
        end
      end
      RECOVER: begin
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        else               state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      romAddr_q  <= '0;
      romOff_q   <= 1'b1;
      rspValid_q <= 1'b0;
      rspData_q  <= '0;
`ifdef EPROM_FETCH_CACHE_EN
      cacheAddr_q  <= '0;
      cacheData_q  <= '0;
      cacheValid_q <= 1'b0;
      hitResp_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      romAddr_q  <= romAddr_d;
      romOff_q   <= romOff_d;
      rspValid_q <= rspValid_d;
      rspData_q  <= rspData_d;
`ifdef EPROM_FETCH_CACHE_EN
      cacheAddr_q  <= cacheAddr_d;
      cacheData_q  <= cacheData_d;
      cacheValid_q <= cacheValid_d;
      hitResp_q    <= hitResp_d;
`endif
    end
  end

  // E and G share one register so they can never skew apart.
  assign rom_e_n   = romOff_q;
  assign rom_g_n   = romOff_q;
  assign rom_addr  = romAddr_q;
  assign rsp_valid = rspValid_q;
  assign rsp_data  = rspData_q;
  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_eprom_fetch_ctrl.sv
// Directed self-checking bench for eprom_fetch_ctrl; the EPROM model returns addr[7:0]^A5 only while E and G are low.
module tb_eprom_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [11:0] req_addr = 12'h000;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_data;
  logic [11:0] rom_addr;
  logic        rom_e_n;
  logic        rom_g_n;
  logic [7:0]  rom_q;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rom_q = (!rom_e_n && !rom_g_n) ? (rom_addr[7:0] ^ 8'hA5) : 8'hxx;

  eprom_fetch_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rom_addr  (rom_addr),
    .rom_e_n   (rom_e_n),
    .rom_g_n   (rom_g_n),
    .rom_q     (rom_q),
    .busy      (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full read: accept, then watch from the negedge after the accept edge until rsp_valid, then consume it.
  task automatic applyStimulus(input logic [11:0] addr, output int lat, output int lowCnt,
                               output int egSkew, output logic [7:0] data);
    int  waitCyc;
    bit  got;
    lat = -1; lowCnt = 0; egSkew = 0; data = 8'h00; got = 1'b0; waitCyc = 0;
    while (!req_ready && waitCyc < 50) begin
      @(negedge clk);
      waitCyc++;
    end
    req_addr  = addr;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = ~addr;
    for (int k = 0; k < 40; k++) begin
      if (!rom_e_n && !rom_g_n) lowCnt++;
      if (rom_e_n !== rom_g_n) egSkew++;
      if (rsp_valid === 1'b1) begin
        lat  = k;
        data = rsp_data;
        got  = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (got) begin
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          lat, lowCnt, egSkew, waitCyc, seen;
    logic [7:0]  data;
    int          accT[10];
    logic [7:0]  got[10];
    int          issued, nRsp, highRun, minGap;
    bit          pend, seenLow;
    bit          stallValid, stallData, stallReady, stallEg, stallBusy;

    // Reset state
    @(negedge clk);
    checkOutput("reset_e_n", rom_e_n, 1);
    checkOutput("reset_g_n", rom_g_n, 1);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_rom_addr", rom_addr, 12'h000);
    checkOutput("reset_rsp_data", rsp_data, 8'h00);
    checkOutput("reset_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("reset_req_ready", req_ready, 1);
    @(negedge clk);

    // Single read of 0x005
    applyStimulus(12'h005, lat, lowCnt, egSkew, data);
    checkOutput("single_latency", lat, 5);
    checkOutput("single_eg_low", lowCnt, 4);
    checkOutput("single_eg_skew", egSkew, 0);
    checkOutput("single_data", data, 8'hA0);
    checkOutput("single_rom_addr_held", rom_addr, 12'h005);
    checkOutput("single_rsp_drop", rsp_valid, 0);

    // Burst 0x000..0x009 with rsp_ready tied high
    waitCyc = 0;
    while (!req_ready && waitCyc < 50) begin
      @(negedge clk);
      waitCyc++;
    end
    rsp_ready = 1'b1;
    req_addr  = 12'h000;
    req_valid = 1'b1;
    issued = 0; nRsp = 0; pend = 1'b0; seenLow = 1'b0; highRun = 0; minGap = 1000;
    for (int i = 0; i < 10; i++) begin
      accT[i] = -100;
      got[i]  = 8'h00;
    end
    for (int c = 0; c < 300 && nRsp < 10; c++) begin
      if (pend) begin
        pend     = 1'b0;
        req_addr = 12'(issued);
        if (issued == 10) req_valid = 1'b0;
      end
      if (req_valid && req_ready && issued < 10) begin
        accT[issued] = c;
        issued++;
        pend = 1'b1;
      end
      if (rsp_valid === 1'b1 && nRsp < 10) begin
        got[nRsp] = rsp_data;
        nRsp++;
      end
      if (rom_e_n) highRun++;
      else begin
        if (seenLow && highRun > 0 && highRun < minGap) minGap = highRun;
        seenLow = 1'b1;
        highRun = 0;
      end
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    checkOutput("burst_rsp_count", nRsp, 10);
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("burst_data_%0d", i), got[i], 32'(8'(i) ^ 8'hA5));
    end
    for (int i = 0; i < 9; i++) begin
      checkOutput($sformatf("burst_spacing_%0d", i), accT[i+1] - accT[i], 8);
    end
    checkOutput("burst_eg_gap_ge2", (minGap >= 2 && minGap < 1000), 1);

    // Back-pressure on 0xFFF
    waitCyc = 0;
    while (!req_ready && waitCyc < 50) begin
      @(negedge clk);
      waitCyc++;
    end
    req_addr  = 12'hFFF;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 12'h000;
    waitCyc = 0;
    while (rsp_valid !== 1'b1 && waitCyc < 40) begin
      @(negedge clk);
      waitCyc++;
    end
    checkOutput("bp_latency", waitCyc, 5);
    stallValid = 1'b1; stallData = 1'b1; stallReady = 1'b1; stallEg = 1'b1; stallBusy = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid !== 1'b1) stallValid = 1'b0;
      if (rsp_data !== 8'h5A) stallData = 1'b0;
      if (req_ready !== 1'b0) stallReady = 1'b0;
      if (rom_e_n !== 1'b1 || rom_g_n !== 1'b1) stallEg = 1'b0;
      if (busy !== 1'b1) stallBusy = 1'b0;
      @(negedge clk);
    end
    checkOutput("bp_valid_held", stallValid, 1);
    checkOutput("bp_data_stable_5A", stallData, 1);
    checkOutput("bp_req_ready_low", stallReady, 1);
    checkOutput("bp_eg_high", stallEg, 1);
    checkOutput("bp_busy", stallBusy, 1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("bp_rsp_drop", rsp_valid, 0);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (rsp_valid === 1'b1) seen++;
      @(negedge clk);
    end
    checkOutput("bp_single_delivery", seen, 0);

    // Reset during the second ACCESS clock of a read to 0x123
    waitCyc = 0;
    while (!req_ready && waitCyc < 50) begin
      @(negedge clk);
      waitCyc++;
    end
    req_addr  = 12'h123;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_mid_eg_low_before", rom_e_n, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_e_high", rom_e_n, 1);
    checkOutput("rst_mid_g_high", rom_g_n, 1);
    checkOutput("rst_mid_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (rsp_valid === 1'b1) seen++;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    checkOutput("rst_mid_no_rsp", seen, 0);
    applyStimulus(12'h124, lat, lowCnt, egSkew, data);
    checkOutput("rst_next_data", data, 8'h81);
    checkOutput("rst_next_latency", lat, 5);

    // Repeat read of 0x010
    applyStimulus(12'h010, lat, lowCnt, egSkew, data);
    checkOutput("rep1_latency", lat, 5);
    checkOutput("rep1_data", data, 8'hB5);
    applyStimulus(12'h010, lat, lowCnt, egSkew, data);
`ifdef EPROM_FETCH_CACHE_EN
    // A hit registers rsp_valid on the accept edge itself, so it is already visible at the first sample.
    checkOutput("rep2_latency", lat, 0);
    checkOutput("rep2_eg_low", lowCnt, 0);
`else
    checkOutput("rep2_latency", lat, 5);
    checkOutput("rep2_eg_low", lowCnt, 4);
`endif
    checkOutput("rep2_data", data, 8'hB5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
